// File: rtl/gpr_seq_pkg.sv
// Shared types and default widths for the GPR command sequencer.
package gpr_seq_pkg;

  localparam int unsigned GPR_DATA_W = 8;
  localparam int unsigned GPR_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LOADI = 2'd0,
    OP_READ  = 2'd1,
    OP_MOVE  = 2'd2,
    OP_ALU   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5,
    ALU_RSV6   = 3'd6,
    ALU_RSV7   = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_ALU_ISSUE,
    S_ALU_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

endpackage

// File: rtl/gpr_sequencer_if.sv
// Command and response handshake bundle between a command source and the sequencer.
interface gpr_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [2:0]        cmd_alu_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_alu_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_alu_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/gpr_seq_alu.sv
// Combinational ALU over the register file's GPR[0]/GPR[1] operand taps.
module gpr_seq_alu
  import gpr_seq_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      ALU_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_PASS_A: result_o = a_i;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gpr_sequencer.sv
// Command-driven master for the 8x8 register file; absorbs its registered read latency.
module gpr_sequencer
  import gpr_seq_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  gpr_sequencer_if.slave    bus,
  output logic              busy,
  output logic [ADDR_W-1:0] gpr_address,
  output logic [DATA_W-1:0] gpr_data_in,
  output logic              gpr_write_enable,
  output logic              gpr_read_enable,
  output logic              gpr_alu_en,
  input  logic [DATA_W-1:0] gpr_data_out,
  input  logic [DATA_W-1:0] gpr_alu_a,
  input  logic [DATA_W-1:0] gpr_alu_b
);

  state_e            state_q;
  cmd_op_e           op_q;
  alu_op_e           alu_op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              cmd_ready_q, rsp_valid_q, busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              we_q, re_q, alu_en_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  gpr_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (gpr_alu_a),
    .b_i      (gpr_alu_b),
    .op_i     (alu_op_q),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  // Pin registers are loaded on entry to the state that owns them, so every
  // GPR-side output is a flop and lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOADI;
      alu_op_q    <= ALU_ADD;
      dst_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      alu_en_q    <= 1'b0;
    end else begin
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      alu_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op_e'(bus.cmd_op);
            alu_op_q    <= alu_op_e'(bus.cmd_alu_op);
            dst_q       <= bus.cmd_dst;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (cmd_op_e'(bus.cmd_op))
              OP_LOADI: begin
                result_q <= bus.cmd_imm;
                carry_q  <= 1'b0;
                addr_q   <= bus.cmd_dst;
                din_q    <= bus.cmd_imm;
                we_q     <= 1'b1;
                state_q  <= S_WRITE;
              end
              OP_READ, OP_MOVE: begin
                addr_q  <= bus.cmd_src;
                re_q    <= 1'b1;
                state_q <= S_RD_ISSUE;
              end
              default: begin
                alu_en_q <= 1'b1;
                state_q  <= S_ALU_ISSUE;
              end
            endcase
          end
        end
        S_RD_ISSUE:  state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          result_q <= gpr_data_out;
          carry_q  <= 1'b0;
          if (op_q == OP_READ) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            addr_q  <= dst_q;
            din_q   <= gpr_data_out;
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_ALU_ISSUE: state_q <= S_ALU_WAIT;
        S_ALU_WAIT: begin
          result_q <= alu_result;
          carry_q  <= alu_carry;
          addr_q   <= dst_q;
          din_q    <= alu_result;
          we_q     <= 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = result_q;
  assign bus.rsp_carry    = carry_q;
  assign busy             = busy_q;
  assign gpr_address      = addr_q;
  assign gpr_data_in      = din_q;
  assign gpr_write_enable = we_q;
  assign gpr_read_enable  = re_q;
  assign gpr_alu_en       = alu_en_q;

endmodule

// File: tb/tb_gpr_sequencer.sv
// Randomized bench: register-file model on the GPR pins, array reference model for results.
module tb_gpr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [2:0] gpr_address;
  logic [7:0] gpr_data_in;
  logic       gpr_write_enable, gpr_read_enable, gpr_alu_en;
  logic [7:0] gpr_data_out = '0;
  logic [7:0] gpr_alu_a = '0;
  logic [7:0] gpr_alu_b = '0;

  logic [7:0] rf [8];
  int         ref_rf [8];
  int         checks = 0;
  int         failures = 0;
  int         wr_cnt = 0;
  int         en_cnt = 0;
  int         pin_err = 0;

  gpr_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  gpr_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .busy             (busy),
    .gpr_address      (gpr_address),
    .gpr_data_in      (gpr_data_in),
    .gpr_write_enable (gpr_write_enable),
    .gpr_read_enable  (gpr_read_enable),
    .gpr_alu_en       (gpr_alu_en),
    .gpr_data_out     (gpr_data_out),
    .gpr_alu_a        (gpr_alu_a),
    .gpr_alu_b        (gpr_alu_b)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) rf[i] = '0;

  // Register file: registered read/ALU taps that fall back to zero when disabled.
  always @(posedge clk) begin
    if (gpr_write_enable) begin
      rf[gpr_address] <= gpr_data_in;
      wr_cnt++;
    end
    gpr_data_out <= gpr_read_enable ? rf[gpr_address] : 8'h00;
    gpr_alu_a    <= gpr_alu_en ? rf[0] : 8'h00;
    gpr_alu_b    <= gpr_alu_en ? rf[1] : 8'h00;
  end

  always @(negedge clk) begin
    if (gpr_write_enable || gpr_read_enable || gpr_alu_en) en_cnt++;
    if ((int'(gpr_write_enable) + int'(gpr_read_enable) + int'(gpr_alu_en)) > 1) pin_err++;
    if (!(gpr_write_enable || gpr_read_enable || gpr_alu_en) &&
        (gpr_address != 3'd0 || gpr_data_in != 8'd0)) pin_err++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pack_outputs();
    return {bus.rsp_valid, bus.rsp_data, bus.rsp_carry, busy, gpr_address,
            gpr_data_in, gpr_write_enable, gpr_read_enable, gpr_alu_en};
  endfunction

  task automatic scramble_cmd();
    bus.cmd_op     = 2'($urandom);
    bus.cmd_alu_op = 3'($urandom);
    bus.cmd_dst    = 3'($urandom);
    bus.cmd_src    = 3'($urandom);
    bus.cmd_imm    = 8'($urandom);
  endtask

  // Issue one command from the idle point (#1 after an edge) and follow it to its handshake.
  task automatic do_cmd(input int op, input int aop, input int dst, input int src,
                        input int imm, input int stall);
    int exp_d, exp_c, exp_lat, n, w0, e0, a, b;
    a = ref_rf[0];
    b = ref_rf[1];
    exp_c = 0;
    case (op)
      0: exp_d = imm;
      1, 2: exp_d = ref_rf[src];
      default: begin
        case (aop)
          0: begin exp_d = (a + b) % 256; exp_c = (a + b) / 256; end
          1: begin exp_d = (a - b + 256) % 256; exp_c = (a < b) ? 1 : 0; end
          2: exp_d = a & b;
          3: exp_d = a | b;
          4: exp_d = a ^ b;
          5: exp_d = a;
          default: exp_d = 0;
        endcase
      end
    endcase
    exp_lat = (op == 0) ? 1 : (op == 1) ? 2 : 3;

    bus.cmd_op     = 2'(op);
    bus.cmd_alu_op = 3'(aop);
    bus.cmd_dst    = 3'(dst);
    bus.cmd_src    = 3'(src);
    bus.cmd_imm    = 8'(imm);
    bus.cmd_valid  = 1'b1;
    bus.rsp_ready  = (stall == 0);
    check_eq("cmd_ready_idle", int'(bus.cmd_ready), 1);
    w0 = wr_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    check_eq("cmd_ready_busy", int'(bus.cmd_ready), 0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rsp_latency", n, exp_lat);
    check_eq("rsp_data", int'(bus.rsp_data), exp_d);
    check_eq("rsp_carry", int'(bus.rsp_carry), exp_c);
    if (stall > 0) begin
      e0 = en_cnt;
      repeat (stall) begin @(posedge clk); #1; end
      check_eq("stall_valid", int'(bus.rsp_valid), 1);
      check_eq("stall_data", int'(bus.rsp_data), exp_d);
      check_eq("stall_gpr_quiet", en_cnt - e0, 0);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("rsp_drop", int'(bus.rsp_valid), 0);
    check_eq("cmd_ready_back", int'(bus.cmd_ready), 1);
    check_eq("write_count", wr_cnt - w0, (op == 1) ? 0 : 1);
    if (op != 1) begin
      ref_rf[dst] = exp_d;
      check_eq("regfile", int'(rf[dst]), exp_d);
    end
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    scramble_cmd();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", pack_outputs(), 0);
    check_eq("reset_cmd_ready", int'(bus.cmd_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_outputs", pack_outputs(), 0);

    do_cmd(0, 0, 5, 0, 8'hA7, 0);
    do_cmd(0, 0, 3, 0, 8'h3C, 0);
    do_cmd(1, 0, 0, 3, 0, 0);
    do_cmd(0, 0, 0, 0, 8'hF0, 0);
    do_cmd(0, 0, 1, 0, 8'h20, 0);
    do_cmd(3, 0, 2, 0, 0, 0);
    check_eq("plan_add_r2", int'(rf[2]), 8'h10);
    do_cmd(0, 0, 0, 0, 8'h10, 0);
    do_cmd(3, 1, 3, 0, 0, 0);
    check_eq("plan_sub_r3", int'(rf[3]), 8'hF0);
    do_cmd(2, 0, 7, 2, 0, 5);
    do_cmd(1, 0, 0, 7, 0, 0);
    do_cmd(2, 0, 4, 4, 0, 0);
    do_cmd(0, 0, 0, 0, 8'h55, 0);
    do_cmd(0, 0, 1, 0, 8'hFF, 0);
    do_cmd(3, 4, 0, 0, 0, 0);
    check_eq("plan_xor_r0", int'(rf[0]), 8'hAA);
    do_cmd(3, 6, 4, 0, 0, 0);
    check_eq("plan_rsv_r4", int'(rf[4]), 0);

    // Reset while the ALU result is being captured: the pending write must vanish.
    bus.cmd_op     = 2'd3;
    bus.cmd_alu_op = 3'd4;
    bus.cmd_dst    = 3'd6;
    bus.cmd_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", pack_outputs(), 0);
    check_eq("async_reset_ready", int'(bus.cmd_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("reset_no_write", wr_cnt - w0, 0);
    check_eq("reset_r6_kept", int'(rf[6]), ref_rf[6]);
    @(posedge clk); #1;
    do_cmd(0, 0, 6, 0, 8'h5A, 0);

    for (int k = 0; k < 80; k++) begin
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    for (int i = 0; i < 8; i++) check_eq("final_regfile", int'(rf[i]), ref_rf[i]);
    check_eq("pin_rules", pin_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
